fft_stage_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_stage_sequencer_if.sv | 28 ++
 rtl/fft_watchdog.sv | 35 +++
 rtl/fft_stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg
// Shared constants and types for the 32-point radix-2 FFT frame sequencer.
//   NUMSTAGES / NUMSAMPLES : frame geometry (NUMSTAGES = log2 NUMSAMPLES)
//   STAGE_TIMEOUT          : default watchdog limit, in RUN cycles per stage
//   STAGE_W / ADDR_W       : widths of the stage index and sample address
//   seq_state_t            : sequencer state encoding
package fft_pkg;

  localparam int NUMSTAGES     = 5;
  localparam int NUMSAMPLES    = 32;
  localparam int STAGE_TIMEOUT = 64;
  localparam int STAGE_W       = 3;
  localparam int ADDR_W        = NUMSTAGES;

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUMSAMPLES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUMSTAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_UNLOAD = 3'd4,
    S_FIN    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if
// Host-side sample streams of the FFT sequencer.
//   in_valid / in_ready / in_addr    : sample load into the FFT memory
//   out_valid / out_ready / out_addr : sample unload from the FFT memory
// Modports:
//   master : host side (offers input samples, accepts output samples)
//   slave  : sequencer side
interface fft_stage_sequencer_if;
  import fft_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, out_ready,
    input  in_ready, in_addr, out_valid, out_addr
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, in_addr, out_valid, out_addr
  );

endinterface

// File: rtl/fft_watchdog.sv
// fft_watchdog
// Per-stage watchdog: a down-counter restarted by clr and decremented while
// en is high. expire flags the terminal count while the counter is enabled,
// i.e. in the TIMEOUT-th enabled cycle after a restart.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (takes priority over en)
//   en         : count this cycle
//   expire     : terminal count reached in an enabled cycle
module fft_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Frame scheduler for the 32-point radix-2 FFT datapath: loads a frame,
// runs every butterfly stage through fft_stage_control, then unloads.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a frame (only looked at in IDLE)
//   bus          : sample load/unload handshakes (slave side)
//   ld_data_r    : 0 = memory in load/unload mode, 1 = compute mode
//   en_r         : stage enable to fft_stage_control
//   stage_num_r  : stage index being computed
//   stage_done   : stage complete, from fft_stage_control
//   busy         : frame in progress
//   done         : one-cycle pulse at frame end (also after a timeout)
//   err_timeout  : sticky; a stage ran too long; cleared by reset or start
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting NUMSAMPLES input samples
// RUN    | stage enabled, waiting for stage_done (watchdog counting)
// GAP    | single cycle with en_r low between two stages
// UNLOAD | presenting NUMSAMPLES output samples
// FIN    | single cycle, done pulse
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  fft_stage_sequencer_if.slave   bus,
  output logic                   ld_data_r,
  output logic                   en_r,
  output logic [STAGE_W-1:0]     stage_num_r,
  input  logic                   stage_done,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);

  seq_state_t        state;
  logic              in_ready_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic in_xfer;
  logic out_xfer;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  assign bus.in_ready  = in_ready_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.out_ready;

  // Restart the watchdog on every edge that lands in RUN.
  assign wd_clr = ((state == S_LOAD) && in_xfer && (in_addr_q == LAST_ADDR)) ||
                  (state == S_GAP);
  assign wd_en  = (state == S_RUN);

  fft_watchdog #(
    .TIMEOUT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b0;
      in_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      ld_data_r   <= 1'b0;
      en_r        <= 1'b0;
      stage_num_r <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            busy        <= 1'b1;
            in_ready_q  <= 1'b1;
            in_addr_q   <= '0;
            ld_data_r   <= 1'b0;
            err_timeout <= 1'b0;
          end
        end

        S_LOAD: begin
          if (in_xfer) begin
            // The address wraps to 0 naturally on the last sample.
            in_addr_q <= in_addr_q + 1'b1;
            if (in_addr_q == LAST_ADDR) begin
              state      <= S_RUN;
              in_ready_q <= 1'b0;
              ld_data_r  <= 1'b1;
              en_r       <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // A stage_done in the watchdog's final cycle still counts as on time.
          if (stage_done) begin
            en_r <= 1'b0;
            if (stage_num_r == LAST_STAGE) begin
              state       <= S_UNLOAD;
              ld_data_r   <= 1'b0;
              out_valid_q <= 1'b1;
              out_addr_q  <= '0;
            end else begin
              state       <= S_GAP;
              stage_num_r <= stage_num_r + 1'b1;
            end
          end else if (wd_expire) begin
            state       <= S_FIN;
            en_r        <= 1'b0;
            ld_data_r   <= 1'b0;
            stage_num_r <= '0;
            err_timeout <= 1'b1;
            done        <= 1'b1;
          end
        end

        S_GAP: begin
          state <= S_RUN;
          en_r  <= 1'b1;
        end

        S_UNLOAD: begin
          if (out_xfer) begin
            out_addr_q <= out_addr_q + 1'b1;
            if (out_addr_q == LAST_ADDR) begin
              state       <= S_FIN;
              out_valid_q <= 1'b0;
              stage_num_r <= '0;
              done        <= 1'b1;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          ld_data_r   <= 1'b0;
          en_r        <= 1'b0;
          stage_num_r <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
// Directed sequence of frames with randomized handshakes, stage lengths and
// spurious inputs, checked against event-level expectations of a frame.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stage_done = 1'b0;
  logic ld_data_r;
  logic en_r;
  logic [STAGE_W-1:0] stage_num_r;
  logic busy;
  logic done;
  logic err_timeout;

  int total = 0;
  int bad = 0;
  int dly[NUMSTAGES];

  fft_stage_sequencer_if bus ();

  fft_stage_sequencer #(
    .TIMEOUT_CYC (STAGE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .ld_data_r   (ld_data_r),
    .en_r        (en_r),
    .stage_num_r (stage_num_r),
    .stage_done  (stage_done),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 0);
    check({tag, "_in_addr"},   32'(bus.in_addr), 0);
    check({tag, "_ld"},        32'(ld_data_r), 0);
    check({tag, "_en"},        32'(en_r), 0);
    check({tag, "_stage"},     32'(stage_num_r), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_addr"},  32'(bus.out_addr), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_err"},       32'(err_timeout), 0);
  endtask

  // One full frame, started from IDLE at a negedge. Stage k is answered with
  // stage_done in its dly[k]-th enabled cycle; dly[k] > STAGE_TIMEOUT means
  // never, which must end the frame by timeout after STAGE_TIMEOUT cycles.
  // in_mode/out_mode: 0 = always ready, 1 = fixed pattern, 2 = random.
  task automatic run_frame(input int in_mode, input int out_mode, input bit spur);
    int n_ld, n_ul, k, kk, en_hi, en_lo, n_done, cyc, to_stage, exp_len;
    bit prev_en, to_seen, ended;
    n_ld = 0; n_ul = 0; k = 0; en_hi = 0; en_lo = 0; n_done = 0; cyc = 0;
    prev_en = 1'b0; to_seen = 1'b0; ended = 1'b0; to_stage = -1;
    for (int i = 0; i < NUMSTAGES; i++)
      if (to_stage < 0 && dly[i] > STAGE_TIMEOUT) to_stage = i;

    start = 1'b1; stage_done = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",     32'(busy), 1);
    check("start_in_ready", 32'(bus.in_ready), 1);
    check("start_in_addr",  32'(bus.in_addr), 0);
    check("start_err_clr",  32'(err_timeout), 0);
    check("start_en",       32'(en_r), 0);
    check("start_stage",    32'(stage_num_r), 0);
    check("start_out_valid",32'(bus.out_valid), 0);

    while (!ended && cyc < 4000) begin
      kk = (k < NUMSTAGES) ? k : NUMSTAGES - 1;
      if (en_r) begin
        if (!prev_en && k > 0) check("gap_len", 32'(en_lo), 1);
        check("run_stage", 32'(stage_num_r), 32'(k));
        check("run_ld", 32'(ld_data_r), 1);
        en_hi++;
      end else if (prev_en) begin
        exp_len = (dly[kk] > STAGE_TIMEOUT) ? STAGE_TIMEOUT : dly[kk];
        check("run_len", 32'(en_hi), 32'(exp_len));
        if (k == to_stage) begin
          check("to_err",    32'(err_timeout), 1);
          check("to_done",   32'(done), 1);
          check("to_stage0", 32'(stage_num_r), 0);
          to_seen = 1'b1;
        end else begin
          check("no_err", 32'(err_timeout), 0);
          if (k < NUMSTAGES - 1) check("gap_stage", 32'(stage_num_r), 32'(k + 1));
        end
        k++; en_hi = 0; en_lo = 1;
      end else if (k > 0) begin
        en_lo++;
      end

      check("in_ready",  32'(bus.in_ready), 32'(n_ld < NUMSAMPLES));
      check("out_valid", 32'(bus.out_valid),
            32'(!to_seen && k == NUMSTAGES && n_ul < NUMSAMPLES));
      if (bus.in_ready || bus.out_valid) check("ld_mode", 32'(ld_data_r), 0);
      if (done) n_done++;

      if (!busy) begin
        ended = 1'b1;
      end else begin
        case (in_mode)
          0:       bus.in_valid = 1'b1;
          1:       bus.in_valid = (cyc % 2 == 0);
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        case (out_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = (cyc % 3 != 2);
          default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (en_r) stage_done = (k < NUMSTAGES) && (en_hi == dly[kk]);
        else      stage_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        start = spur ? 1'($urandom_range(0, 1)) : 1'b0;

        if (bus.in_ready && bus.in_valid) begin
          check("in_addr", 32'(bus.in_addr), 32'(n_ld % NUMSAMPLES));
          n_ld++;
        end
        if (bus.out_valid && bus.out_ready) begin
          check("out_addr", 32'(bus.out_addr), 32'(n_ul % NUMSAMPLES));
          n_ul++;
        end
        prev_en = en_r;
        @(negedge clk);
        cyc++;
      end
    end

    start = 1'b0; stage_done = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("frame_ended",  32'(ended), 1);
    check("done_count",   32'(n_done), 1);
    check("load_count",   32'(n_ld), 32'(NUMSAMPLES));
    check("unload_count", 32'(n_ul), (to_stage >= 0) ? 0 : 32'(NUMSAMPLES));
    check("stages_run",   32'(k), (to_stage >= 0) ? 32'(to_stage + 1) : 32'(NUMSTAGES));
    check("end_err",      32'(err_timeout), 32'(to_stage >= 0));
    check("end_done_low", 32'(done), 0);
    if (!ended) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    int steps;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Power-up reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of LOAD.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    steps = 0;
    while (bus.in_addr != 5'd17 && steps < 40) begin
      @(negedge clk);
      steps++;
    end
    check("midload_addr", 32'(bus.in_addr), 17);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check_all_zero("midload_rst");
    @(negedge clk);
    check("midload_stay_idle", 32'(busy), 0);

    // Nominal frame: stage_done 8 cycles into each stage.
    for (int i = 0; i < NUMSTAGES; i++) dly[i] = 8;
    run_frame(0, 0, 1'b0);

    // Back-to-back with backpressure patterns.
    run_frame(1, 1, 1'b0);

    // Stage 2 never completes: watchdog ends the frame.
    for (int i = 0; i < NUMSTAGES; i++) dly[i] = 8;
    dly[2] = 1000;
    run_frame(0, 0, 1'b1);

    // Next frame must clear the sticky error.
    for (int i = 0; i < NUMSTAGES; i++) dly[i] = $urandom_range(1, 20);
    run_frame(0, 0, 1'b1);

    // Boundaries: 1-cycle stage and stage_done in the very last allowed cycle.
    for (int i = 0; i < NUMSTAGES; i++) dly[i] = $urandom_range(2, 30);
    dly[0] = 1;
    dly[4] = STAGE_TIMEOUT;
    run_frame(2, 2, 1'b1);

    // Timeout one cycle past the limit, on the last stage.
    for (int i = 0; i < NUMSTAGES; i++) dly[i] = $urandom_range(1, 30);
    dly[4] = STAGE_TIMEOUT + 1;
    run_frame(2, 1, 1'b1);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NUMSTAGES; i++) dly[i] = $urandom_range(1, 40);
      run_frame(2, 2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
